tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 8, width in bits of each channel word.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  W  time-multiplexed word for the current slot.
REQ-006 Port: in_valid  input  1  din/fs qualifier; one word accepted per clock while high.
REQ-007 Port: fs  input  1  frame sync, high with the slot-0 word; ignored when in_valid=0.
REQ-008 Port: y0, y1, y2, y3  output  W each  demultiplexed channel words of the last complete frame.
REQ-009 Port: out_valid  output  1  one-cycle pulse; y0..y3 updated with a new frame.
REQ-010 Port: locked  output  1  high while the block is in state LOCKED.
REQ-011 Port: sync_err  output  1  one-cycle pulse on a frame-alignment violation.

Function
REQ-012 The block SHALL be the receive end of a 4:1 word-interleaved TDM link, with slots 0,1,2,3 in that order per frame.
REQ-013 State machine: two states, HUNT and LOCKED, plus a 2-bit slot counter cnt and shadow registers s0, s1, s2 (W bits each).
REQ-014 Accept condition: an accept is a rising edge with in_valid=1; with in_valid=0, state, cnt, shadows and y0..y3 SHALL hold and out_valid and sync_err SHALL be 0.
REQ-015 HUNT, accept with fs=0: discard the word, stay in HUNT.
REQ-016 HUNT, accept with fs=1: s0<=din, cnt<=1, go to LOCKED.
REQ-017 LOCKED, accept with fs=1 and cnt=0: s0<=din, cnt<=1 (normal frame start).
REQ-018 LOCKED, accept with fs=0 and cnt=1 or 2: s[cnt]<=din, cnt<=cnt+1.
REQ-019 LOCKED, accept with fs=0 and cnt=3:
  - y0<=s0, y1<=s1, y2<=s2, y3<=din in the same edge;
  - out_valid=1 for the following cycle;
  - cnt wraps to 0.
REQ-020 LOCKED, accept with fs=1 and cnt!=0 (early sync):
  - sync_err=1 for one cycle;
  - discard the partial frame; y0..y3 unchanged, no out_valid;
  - s0<=din, cnt<=1, remain LOCKED.
REQ-021 LOCKED, accept with fs=0 and cnt=0 (missing sync): sync_err=1 for one cycle, discard the word, go to HUNT.
REQ-022 Latency: y0..y3 and out_valid SHALL change on the same edge that accepts slot 3; the first frame is available 4 accepts after a valid fs, with idle cycles allowed between accepts.
REQ-023 Registered outputs: out_valid, sync_err and locked SHALL be registered with no combinational path from inputs.
REQ-024 Gaps: in_valid gaps of any length SHALL NOT affect alignment.

Reset
REQ-025 While rst=1 the block SHALL asynchronously force:
  - state=HUNT, cnt=0, s0..s2=0;
  - y0..y3=0, out_valid=0, locked=0, sync_err=0.
REQ-026 Reset mid-frame: reset SHALL discard the partial frame; after release, no out_valid until a full fs-aligned frame is accepted.

Verification
REQ-027 Aligned frame: after reset, accept (fs=1,0x11),(0,0x22),(0,0x33),(0,0x44) -> locked=1 after the first edge; out_valid pulses once; y0..y3=0x11,0x22,0x33,0x44.
REQ-028 Hunt discard: accept 0xAA,0xBB with fs=0, then an aligned frame 0x01..0x04 -> no out_valid and no sync_err before the frame; y=0x01,0x02,0x03,0x04.
REQ-029 Early sync: aligned frame A, then (fs=1,0x55),(0,0x66),(fs=1,0x77),(0,0x88),(0,0x99),(0,0xCC) -> one sync_err pulse; y keeps frame A until out_valid; then y=0x77,0x88,0x99,0xCC; locked stays 1.
REQ-030 Missing sync: after a frame, accept (fs=0,0x10) at cnt=0 -> sync_err pulse, locked=0, no out_valid.
REQ-031 Gaps and reset: an aligned frame with 3 idle cycles between each accept yields the same y as back-to-back input; rst asserted after slot 2 -> all outputs 0 immediately and no out_valid after release.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4:1 word-interleaved TDM link.
// Collects slots 0..3 of each frame and presents them together on y0..y3,
// tracking frame alignment through the fs marker on slot 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | not aligned; words are discarded until one arrives with fs=1
// LOCKED | aligned; cnt is the slot index expected on the next accept
module tdm_demux4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         in_valid,
  input  logic         fs,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         out_valid,
  output logic         locked,
  output logic         sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [1:0]   cnt, cnt_nxt;
  logic [W-1:0] s0, s1, s2;
  logic         wr_s0, wr_s1, wr_s2, load_y, err;

  // State register and slot counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and slot-count decode; idle cycles leave everything alone
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (fs) begin
            state_nxt = LOCKED;
            cnt_nxt   = 2'd1;
          end
        end
        LOCKED: begin
          if (fs) begin
            cnt_nxt = 2'd1;
          end else if (cnt == 2'd0) begin
            state_nxt = HUNT;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Datapath strobes: which shadow to write, frame completion, alignment error
  always_comb begin
    wr_s0  = 1'b0;
    wr_s1  = 1'b0;
    wr_s2  = 1'b0;
    load_y = 1'b0;
    err    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: wr_s0 = fs;
        LOCKED: begin
          if (fs) begin
            // fs always restarts the frame; if mid-frame the partial one is dropped
            wr_s0 = 1'b1;
            err   = (cnt != 2'd0);
          end else begin
            case (cnt)
              2'd0: err    = 1'b1;
              2'd1: wr_s1  = 1'b1;
              2'd2: wr_s2  = 1'b1;
              2'd3: load_y = 1'b1;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow registers hold slots 0..2 of the frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (wr_s0) s0 <= din;
      if (wr_s1) s1 <= din;
      if (wr_s2) s2 <= din;
    end
  end

  // Output registers; slot 3 goes straight to y3 on the completing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      if (load_y) begin
        y0 <= s0;
        y1 <= s1;
        y2 <= s2;
        y3 <= din;
      end
      out_valid <= load_y;
      sync_err  <= err;
      locked    <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with hand-computed expectations.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         in_valid;
  logic         fs;
  logic [W-1:0] y0, y1, y2, y3;
  logic         out_valid, locked, sync_err;

  int n_chk = 0;
  int n_err = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .fs(fs),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One accept, then 'idle' cycles with in_valid low; returns 1ns after the accept edge
  task automatic send(input logic f, input logic [W-1:0] d);
    in_valid = 1'b1;
    fs       = f;
    din      = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fs       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] ys();
    return {y0, y1, y2, y3};
  endfunction

  function automatic logic [2:0] flags();
    return {out_valid, locked, sync_err};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; fs = 1'b0; din = '0;
    idle(2);
    chk("reset_y", ys(), 32'h0);
    chk("reset_flags", {29'd0, flags()}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Aligned frame
    send(1'b1, 8'h11);
    chk("a_slot0_flags", {29'd0, flags()}, 32'b010);
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    chk("a_slot2_flags", {29'd0, flags()}, 32'b010);
    chk("a_slot2_y", ys(), 32'h0);
    send(1'b0, 8'h44);
    chk("a_done_flags", {29'd0, flags()}, 32'b110);
    chk("a_done_y", ys(), 32'h11223344);
    idle(1);
    chk("a_pulse_once", {31'd0, out_valid}, 32'd0);
    chk("a_hold_y", ys(), 32'h11223344);

    // Early sync: partial frame 55,66 dropped
    send(1'b1, 8'h55);
    send(1'b0, 8'h66);
    chk("e_pre_err", {31'd0, sync_err}, 32'd0);
    send(1'b1, 8'h77);
    chk("e_err_flags", {29'd0, flags()}, 32'b011);
    chk("e_keep_y", ys(), 32'h11223344);
    send(1'b0, 8'h88);
    chk("e_err_once", {29'd0, flags()}, 32'b010);
    send(1'b0, 8'h99);
    chk("e_keep_y2", ys(), 32'h11223344);
    send(1'b0, 8'hCC);
    chk("e_done_flags", {29'd0, flags()}, 32'b110);
    chk("e_done_y", ys(), 32'h778899CC);

    // Missing sync at cnt=0
    send(1'b0, 8'h10);
    chk("m_flags", {29'd0, flags()}, 32'b001);
    chk("m_keep_y", ys(), 32'h778899CC);
    idle(1);
    chk("m_err_once", {29'd0, flags()}, 32'b000);

    // Hunt discard then aligned frame
    send(1'b0, 8'hAA);
    chk("h_aa_flags", {29'd0, flags()}, 32'b000);
    send(1'b0, 8'hBB);
    chk("h_bb_flags", {29'd0, flags()}, 32'b000);
    send(1'b1, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    chk("h_pre_done", {29'd0, flags()}, 32'b010);
    send(1'b0, 8'h04);
    chk("h_done_flags", {29'd0, flags()}, 32'b110);
    chk("h_done_y", ys(), 32'h01020304);

    // Gaps of 3 idle cycles between accepts
    send(1'b1, 8'h11); idle(3);
    chk("g_gap_flags", {29'd0, flags()}, 32'b010);
    send(1'b0, 8'h22); idle(3);
    send(1'b0, 8'h33); idle(3);
    chk("g_gap_y", ys(), 32'h01020304);
    send(1'b0, 8'h44);
    chk("g_done_flags", {29'd0, flags()}, 32'b110);
    chk("g_done_y", ys(), 32'h11223344);
    idle(3);
    chk("g_after_flags", {29'd0, flags()}, 32'b010);

    // Reset after slot 2
    send(1'b1, 8'hA1);
    send(1'b0, 8'hA2);
    send(1'b0, 8'hA3);
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_y", ys(), 32'h0);
    chk("r_async_flags", {29'd0, flags()}, 32'd0);
    idle(1);
    rst = 1'b0;
    send(1'b0, 8'hA4);
    chk("r_after_flags", {29'd0, flags()}, 32'b000);
    chk("r_after_y", ys(), 32'h0);
    send(1'b0, 8'hA5);
    send(1'b0, 8'hA6);
    send(1'b0, 8'hA7);
    chk("r_no_frame", {29'd0, flags()}, 32'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
